// File: rtl/mac_feeder.sv
// Operand-pair FIFO plus sequencer that streams len pairs into an external MAC
// and captures the accumulated dot-product once the MAC has settled.
module mac_feeder #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [7:0]  a_in,
    input  logic [7:0]  b_in,
    input  logic        start,
    input  logic [3:0]  len,
    input  logic [23:0] mac_cout,
    output logic        mac_en,
    output logic        mac_clr,
    output logic [7:0]  mac_a,
    output logic [7:0]  mac_b,
    output logic [23:0] result,
    output logic        done,
    output logic        busy,
    output logic        start_err,
    output logic        full,
    output logic        empty
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_STREAM  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [15:0] mem_r [DEPTH];
    logic [2:0]  wr_ptr_r;
    logic [2:0]  rd_ptr_r;
    logic [3:0]  count_r;
    logic [3:0]  remaining_r;
    logic        push_s;
    logic        pop_s;
    logic        start_ok_s;
    logic        accept_s;
    logic        start_err_s;
    logic        mac_en_s;
    logic        mac_clr_s;
    logic        done_s;
    logic        busy_s;
    logic        mac_en_r;
    logic        mac_clr_r;
    logic [7:0]  mac_a_r;
    logic [7:0]  mac_b_r;
    logic [23:0] result_r;
    logic        done_r;
    logic        busy_r;
    logic        start_err_r;

    assign full       = (count_r == 4'(DEPTH));
    assign empty      = (count_r == 4'd0);
    assign push_s     = wr_en && !full;
    assign start_ok_s = (len != 4'd0) && (len <= 4'd8) && (count_r >= len);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; remaining_r counts pairs still to be popped
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && start_ok_s) begin
                    next_state_s = ST_CLEAR;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CLEAR: next_state_s = ST_STREAM;
            ST_STREAM: begin
                if (remaining_r == 4'd0) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_STREAM;
                end
            end
            ST_WAIT:    next_state_s = ST_CAPTURE;
            ST_CAPTURE: next_state_s = ST_IDLE;
            default:    next_state_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so registered outputs align with it
    always_comb begin
        accept_s    = (state_r == ST_IDLE) && (next_state_s == ST_CLEAR);
        start_err_s = (state_r == ST_IDLE) && start && !start_ok_s;
        mac_clr_s   = (next_state_s == ST_CLEAR);
        mac_en_s    = (next_state_s == ST_STREAM);
        pop_s       = mac_en_s;
        done_s      = (next_state_s == ST_CAPTURE);
        busy_s      = (next_state_s != ST_IDLE);
    end

    // Pair storage, no reset needed: contents are only read behind count_r
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {a_in, b_in};
        end
    end

    // FIFO pointers, occupancy and job length counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= 3'd0;
            rd_ptr_r    <= 3'd0;
            count_r     <= 4'd0;
            remaining_r <= 4'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 3'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 3'd1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 4'd1;
                2'b01:   count_r <= count_r - 4'd1;
                default: count_r <= count_r;
            endcase
            if (accept_s) begin
                remaining_r <= len;
            end else if (pop_s) begin
                remaining_r <= remaining_r - 4'd1;
            end
        end
    end

    // Registered MAC drive and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_en_r    <= 1'b0;
            mac_clr_r   <= 1'b0;
            mac_a_r     <= 8'd0;
            mac_b_r     <= 8'd0;
            result_r    <= 24'd0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            start_err_r <= 1'b0;
        end else begin
            mac_en_r    <= mac_en_s;
            mac_clr_r   <= mac_clr_s;
            done_r      <= done_s;
            busy_r      <= busy_s;
            start_err_r <= start_err_s;
            if (pop_s) begin
                mac_a_r <= mem_r[rd_ptr_r][15:8];
                mac_b_r <= mem_r[rd_ptr_r][7:0];
            end
            if (done_s) begin
                result_r <= mac_cout;
            end
        end
    end

    assign mac_en    = mac_en_r;
    assign mac_clr   = mac_clr_r;
    assign mac_a     = mac_a_r;
    assign mac_b     = mac_b_r;
    assign result    = result_r;
    assign done      = done_r;
    assign busy      = busy_r;
    assign start_err = start_err_r;

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder: a behavioural downstream MAC plus a queue-based model
// of the pair FIFO and dot-product results.
module tb_mac_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  a_in = 8'd0;
    logic [7:0]  b_in = 8'd0;
    logic        start = 1'b0;
    logic [3:0]  len = 4'd0;
    logic [23:0] mac_cout;
    logic        mac_en, mac_clr, done, busy, start_err, full, empty;
    logic [7:0]  mac_a, mac_b;
    logic [23:0] result;

    logic [23:0] acc;
    logic [15:0] ref_q[$];
    int total = 0;
    int bad = 0;

    mac_feeder #(.DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .a_in(a_in), .b_in(b_in),
        .start(start), .len(len), .mac_cout(mac_cout),
        .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
        .result(result), .done(done), .busy(busy), .start_err(start_err),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Downstream MAC: clears or accumulates one edge after the feeder asks
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= 24'd0;
        else if (mac_clr) acc <= 24'd0;
        else if (mac_en) acc <= acc + 24'(mac_a) * 24'(mac_b);
    end
    assign mac_cout = acc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
        wr_en = 1'b1; a_in = a; b_in = b;
        tick();
        wr_en = 1'b0;
        if (ref_q.size() < 8) ref_q.push_back({a, b});
        total++; if (full !== (ref_q.size() == 8)) begin bad++; $display("FAIL push_full got=%b exp=%0d", full, ref_q.size() == 8); end
        total++; if (empty !== (ref_q.size() == 0)) begin bad++; $display("FAIL push_empty got=%b exp=%0d", empty, ref_q.size() == 0); end
    endtask

    task automatic run_job(input int n, input bit push_during, input bit b2b);
        logic [23:0] exp_sum;
        logic [15:0] pr;
        logic [15:0] np;
        bit full_pre;
        exp_sum = 24'd0;
        pr = 16'd0;
        np = 16'd0;
        start = 1'b1; len = 4'(n);
        tick();
        start = 1'b0;
        total++; if (mac_clr !== 1'b1) begin bad++; $display("FAIL e0_mac_clr got=%b exp=1", mac_clr); end
        total++; if (mac_en !== 1'b0) begin bad++; $display("FAIL e0_mac_en got=%b exp=0", mac_en); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL e0_busy got=%b exp=1", busy); end
        total++; if (start_err !== 1'b0) begin bad++; $display("FAIL e0_start_err got=%b exp=0", start_err); end
        for (int k = 1; k <= n; k++) begin
            if (push_during) begin
                np = 16'($urandom);
                wr_en = 1'b1; a_in = np[15:8]; b_in = np[7:0];
            end
            tick();
            full_pre = (ref_q.size() == 8);
            pr = ref_q.pop_front();
            if (push_during && !full_pre) ref_q.push_back(np);
            exp_sum = exp_sum + 24'(pr[15:8]) * 24'(pr[7:0]);
            total++; if (mac_en !== 1'b1) begin bad++; $display("FAIL stream_mac_en k=%0d got=%b exp=1", k, mac_en); end
            total++; if (mac_clr !== 1'b0) begin bad++; $display("FAIL stream_mac_clr k=%0d got=%b exp=0", k, mac_clr); end
            total++; if ({mac_a, mac_b} !== pr) begin bad++; $display("FAIL stream_pair k=%0d got=%h exp=%h", k, {mac_a, mac_b}, pr); end
            total++; if (empty !== (ref_q.size() == 0)) begin bad++; $display("FAIL stream_empty k=%0d got=%b exp=%0d", k, empty, ref_q.size() == 0); end
        end
        wr_en = 1'b0;
        tick();
        total++; if (mac_en !== 1'b0) begin bad++; $display("FAIL wait_mac_en got=%b exp=0", mac_en); end
        total++; if ({mac_a, mac_b} !== pr) begin bad++; $display("FAIL wait_hold got=%h exp=%h", {mac_a, mac_b}, pr); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL wait_done got=%b exp=0", done); end
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL capture_done got=%b exp=1", done); end
        total++; if (result !== exp_sum) begin bad++; $display("FAIL capture_result got=%0d exp=%0d", result, exp_sum); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL capture_busy got=%b exp=1", busy); end
        if (b2b) begin start = 1'b1; len = 4'd1; end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL after_done got=%b exp=0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL after_busy got=%b exp=0", busy); end
        total++; if (result !== exp_sum) begin bad++; $display("FAIL after_result got=%0d exp=%0d", result, exp_sum); end
        total++; if (start_err !== 1'b0) begin bad++; $display("FAIL after_start_err got=%b exp=0", start_err); end
        total++; if (mac_clr !== 1'b0) begin bad++; $display("FAIL after_mac_clr got=%b exp=0", mac_clr); end
    endtask

    task automatic check_idle_zero(input string tag);
        total++; if ({mac_en, mac_clr, done, busy, start_err} !== 5'b0) begin bad++; $display("FAIL %s_ctrl got=%b exp=00000", tag, {mac_en, mac_clr, done, busy, start_err}); end
        total++; if ({mac_a, mac_b} !== 16'd0) begin bad++; $display("FAIL %s_operands got=%h exp=0000", tag, {mac_a, mac_b}); end
        total++; if (result !== 24'd0) begin bad++; $display("FAIL %s_result got=%0d exp=0", tag, result); end
        total++; if ({full, empty} !== 2'b01) begin bad++; $display("FAIL %s_flags got=%b exp=01", tag, {full, empty}); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        check_idle_zero("reset");
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        push_pair(8'd2, 8'd3);
        push_pair(8'd4, 8'd5);
        run_job(2, 1'b0, 1'b0);
        total++; if (result !== 24'd26) begin bad++; $display("FAIL basic_result got=%0d exp=26", result); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL basic_empty got=%b exp=1", empty); end
    endtask

    task automatic test_max();
        for (int i = 0; i < 8; i++) push_pair(8'd255, 8'd255);
        run_job(8, 1'b0, 1'b0);
        total++; if (result !== 24'h07F008) begin bad++; $display("FAIL max_result got=%h exp=07f008", result); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) push_pair(8'($urandom), 8'($urandom));
        push_pair(8'd9, 8'd9);
        total++; if (full !== 1'b1) begin bad++; $display("FAIL full_flag got=%b exp=1", full); end
        run_job(8, 1'b0, 1'b0);
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_drained got=%b exp=1", empty); end
    endtask

    task automatic test_start_err();
        logic [3:0] bad_len [3];
        bad_len[0] = 4'd3; bad_len[1] = 4'd0; bad_len[2] = 4'd9;
        push_pair(8'd7, 8'd6);
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; len = bad_len[i];
            tick();
            start = 1'b0;
            total++; if (start_err !== 1'b1) begin bad++; $display("FAIL err_pulse len=%0d got=%b exp=1", bad_len[i], start_err); end
            total++; if ({busy, mac_clr} !== 2'b00) begin bad++; $display("FAIL err_idle len=%0d got=%b exp=00", bad_len[i], {busy, mac_clr}); end
            tick();
            total++; if (start_err !== 1'b0) begin bad++; $display("FAIL err_single len=%0d got=%b exp=0", bad_len[i], start_err); end
            total++; if (mac_en !== 1'b0) begin bad++; $display("FAIL err_mac_en len=%0d got=%b exp=0", bad_len[i], mac_en); end
            total++; if (empty !== 1'b0) begin bad++; $display("FAIL err_fifo len=%0d got=%b exp=0", bad_len[i], empty); end
        end
        run_job(1, 1'b0, 1'b0);
    endtask

    task automatic test_stream_push();
        for (int i = 0; i < 4; i++) push_pair(8'($urandom), 8'($urandom));
        run_job(4, 1'b1, 1'b0);
        total++; if (ref_q.size() != 4 || empty !== 1'b0) begin bad++; $display("FAIL stream_push_count model=%0d empty=%b exp=4/0", ref_q.size(), empty); end
        start = 1'b1; len = 4'd5;
        tick();
        start = 1'b0;
        total++; if (start_err !== 1'b1) begin bad++; $display("FAIL stream_push_short got=%b exp=1", start_err); end
        tick();
        run_job(4, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) push_pair(8'($urandom), 8'($urandom));
        run_job(2, 1'b0, 1'b1);
        run_job(1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) push_pair(8'($urandom), 8'($urandom));
            run_job(n, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) push_pair(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
        start = 1'b1; len = 4'd8;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        total++; if (mac_en !== 1'b1) begin bad++; $display("FAIL mid_streaming got=%b exp=1", mac_en); end
        rst_n = 1'b0;
        #1;
        check_idle_zero("mid_reset");
        ref_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_no_done got=%b exp=0", done); end
        push_pair(8'd1, 8'd1);
        run_job(1, 1'b0, 1'b0);
        total++; if (result !== 24'd1) begin bad++; $display("FAIL mid_after_result got=%0d exp=1", result); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_full();
        test_start_err();
        test_stream_push();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 Parameter DEPTH, default 8, operand-pair FIFO depth; fixed at 8 (3-bit pointers, 4-bit count).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 wr_en  input  1  push {a_in,b_in} as one pair this cycle.
REQ-005 a_in  input  8  unsigned operand A.
REQ-006 b_in  input  8  unsigned operand B.
REQ-007 start  input  1  request a dot-product of len pairs.
REQ-008 len  input  4  pairs to consume, legal 1..8, sampled with start.
REQ-009 mac_cout  input  24  accumulated result returned by downstream MAC.
REQ-010 mac_en  output  1  registered; MAC accumulates mac_a*mac_b this cycle.
REQ-011 mac_clr  output  1  registered; MAC clears accumulator to 0.
REQ-012 mac_a  output  8  registered operand A to MAC.
REQ-013 mac_b  output  8  registered operand B to MAC.
REQ-014 result  output  24  last captured dot-product.
REQ-015 done  output  1  one-cycle pulse when result updated.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 start_err  output  1  one-cycle pulse when start rejected.
REQ-018 full  output  1  count==8.
REQ-019 empty  output  1  count==0.

Function
REQ-020 Downstream contract: MAC register updates one edge after mac_clr (to 0) or mac_en (Cout+mac_a*mac_b); feeder never asserts both together.
REQ-021 FIFO: single write pointer, single read pointer, both wrap 7->0; count 0..8.
REQ-022 Push when wr_en && !full; push with full=1 dropped silently, no state change.
REQ-023 Pop only in STREAM, one pair per cycle; pop with simultaneous push leaves count unchanged.
REQ-024 FSM states IDLE, CLEAR, STREAM, WAIT, CAPTURE.
REQ-025 IDLE: start && 1<=len<=8 && count>=len -> CLEAR, latch len into remaining counter.
REQ-026 IDLE: start with len==0, len>8, or count<len -> stay IDLE, start_err=1 next cycle, FIFO untouched.
REQ-027 start outside IDLE ignored, no start_err.
REQ-028 CLEAR (1 cycle): mac_clr=1, mac_en=0 -> STREAM.
REQ-029 STREAM: mac_en=1, mac_a/mac_b = popped head pair, remaining decremented; after len cycles -> WAIT.
REQ-030 WAIT (1 cycle): mac_en=0, mac_a/mac_b hold last values -> CAPTURE.
REQ-031 CAPTURE (1 cycle): result <= mac_cout, done=1 -> IDLE.
REQ-032 Timing: start accepted at edge E0; mac_clr high E0..E1; mac_en high E1..E(len+1); done high E(len+2)..E(len+3); busy low again after E(len+3).
REQ-033 Back-to-back: start in cycle done is high is sampled in IDLE only on following cycle; no pipelining between jobs.
REQ-034 Widths: result zero-extended 24-bit; max 8*255*255=520200 fits, no overflow handling.
REQ-035 mac_a/mac_b hold previous value whenever mac_en=0.

Reset
REQ-036 rst_n low: state IDLE, pointers/count 0, empty=1, full=0, mac_en=mac_clr=0, mac_a=mac_b=0, result=0, done=busy=start_err=0.
REQ-037 Reset mid-operation aborts job, discards all FIFO contents, result returns to 0; no done pulse.

Verification
REQ-038 Push (2,3),(4,5); start len=2 -> mac_clr one cycle, mac_en two cycles, done at E4, result=26, empty=1.
REQ-039 Push 8x(255,255), start len=8 -> result=0x07F008 (520200), done at E10.
REQ-040 Push 9 pairs, 9th=(9,9) -> full=1, count 8, 9th dropped; len=8 sum excludes 81.
REQ-041 Push 1 pair, start len=3; then start len=0 -> start_err pulse each time, no mac_en, count stays 1.
REQ-042 Push during STREAM every cycle -> count constant, pushed pairs available to next job in order.
REQ-043 Assert rst_n low during STREAM of len=8 job -> all outputs reset values, empty=1, subsequent job (1,1) len=1 -> result=1.
